// File: rtl/dds_pkg.sv
// Shared definitions for the DDS core and its receive-side monitor blocks.
package dds_pkg;
    localparam int          PHASE_W  = 32;
    localparam logic [15:0] MIDSCALE = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        DIVIDE,
        DONE
    } state_t;
endpackage

// File: rtl/dds_seq_divider.sv
// Generic restoring divider: one quotient bit per clock, DVD_W clocks after start.
module dds_seq_divider #(
    parameter int DVD_W = 35,
    parameter int DVS_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int STEP_W = $clog2(DVD_W + 1);

    logic [STEP_W-1:0] steps;
    logic [DVS_W-1:0]  rem;
    logic [DVS_W-1:0]  dvs;
    logic [DVS_W:0]    trial;
    logic [DVS_W:0]    diff;
    logic              fits;

    // quotient doubles as the dividend shift register: dividend bits leave
    // the top while quotient bits enter the bottom.
    assign trial = {rem, quotient[DVD_W-1]};
    assign diff  = trial - {1'b0, dvs};
    assign fits  = (trial >= {1'b0, dvs});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                steps <= STEP_W'(DVD_W);
            end else if (steps != '0) begin
                steps <= steps - 1'b1;
                if (steps == STEP_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quotient <= dividend;
            dvs      <= divisor;
            rem      <= '0;
        end else if (steps != '0) begin
            rem      <= fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
            quotient <= {quotient[DVD_W-2:0], fits};
        end
    end
endmodule

// File: rtl/dds_freq_estimator.sv
// Recovers the DDS tuning word from a sampled sine: counts samples over
// N_CYCLES hysteretic midscale crossings, then divides N_CYCLES*2^32 by that count.
module dds_freq_estimator
    import dds_pkg::*;
#(
    parameter int          N_CYCLES = 4,
    parameter int          CNT_W    = 24,
    parameter logic [15:0] HYST     = 16'h0400
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [15:0]         sample_in,
    input  logic                sample_valid,
    output logic [PHASE_W-1:0]  freq_word_out,
    output logic                result_valid,
    output logic                busy,
    output logic                no_signal
);
    localparam int                CYC_W     = $clog2(N_CYCLES + 1);
    localparam int                DVD_W     = PHASE_W + CYC_W;
    localparam logic [15:0]       ARM_LEVEL = MIDSCALE - HYST;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DVD_W-1:0]  DIVIDEND  = {CYC_W'(N_CYCLES), {PHASE_W{1'b0}}};

    state_t             state, state_nx;
    logic [CNT_W-1:0]   counter, counter_nx, counter_inc;
    logic [CYC_W-1:0]   cyc, cyc_nx, cyc_inc;
    logic               armed, armed_nx;
    logic [PHASE_W-1:0] freq_nx;
    logic               valid_nx, nosig_nx, busy_nx;
    logic               below, crossing;
    logic               div_start, div_done, saturated;
    logic [DVD_W-1:0]   quotient;

    assign below       = (sample_in < ARM_LEVEL);
    assign crossing    = armed && (sample_in >= MIDSCALE);
    assign counter_inc = counter + 1'b1;
    assign cyc_inc     = cyc + 1'b1;
    assign saturated   = |quotient[DVD_W-1:PHASE_W];

    // Divisor is the count including the final crossing sample, so never zero.
    dds_seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (counter_inc),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        cyc_nx     = cyc;
        armed_nx   = armed;
        freq_nx    = freq_word_out;
        valid_nx   = 1'b0;
        nosig_nx   = no_signal;
        div_start  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nx   = ARM;
                    counter_nx = '0;
                    armed_nx   = 1'b0;
                end
                ARM, MEASURE: begin
                    if (sample_valid) begin
                        if (crossing) begin
                            armed_nx = 1'b0;
                        end else if (below) begin
                            armed_nx = 1'b1;
                        end
                        // Timeout takes precedence over any crossing on the same sample.
                        if (counter == CNT_MAX) begin
                            nosig_nx   = 1'b1;
                            state_nx   = ARM;
                            counter_nx = '0;
                        end else if (state == ARM) begin
                            if (crossing) begin
                                state_nx   = MEASURE;
                                counter_nx = '0;
                                cyc_nx     = '0;
                            end else begin
                                counter_nx = counter_inc;
                            end
                        end else begin
                            counter_nx = counter_inc;
                            if (crossing) begin
                                cyc_nx = cyc_inc;
                                if (cyc_inc == CYC_W'(N_CYCLES)) begin
                                    state_nx  = DIVIDE;
                                    div_start = 1'b1;
                                end
                            end
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    freq_nx    = saturated ? '1 : quotient[PHASE_W-1:0];
                    valid_nx   = 1'b1;
                    nosig_nx   = 1'b0;
                    state_nx   = ARM;
                    counter_nx = '0;
                    armed_nx   = 1'b0;
                end
                default: state_nx = IDLE;
            endcase
        end
        busy_nx = (state_nx == MEASURE) || (state_nx == DIVIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            cyc           <= '0;
            armed         <= 1'b0;
            freq_word_out <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            state         <= state_nx;
            counter       <= counter_nx;
            cyc           <= cyc_nx;
            armed         <= armed_nx;
            freq_word_out <= freq_nx;
            result_valid  <= valid_nx;
            busy          <= busy_nx;
            no_signal     <= nosig_nx;
        end
    end
endmodule
